bus1_sram_responder: RTL

- Responder (slave) end of the CPU-side bus (C1/A1/D1): accepts read, write and invalidate commands from a CPU initiator and answers after a fixed latency from an internal byte-addressed SRAM.
- Stands in for the cache plus memory controller pair when the CPU model runs alone, and serves as a golden flat-memory reference for cache regressions.
- Owns C1/D1 only during its response window.

---
 rtl/bus1_pkg.sv | 79 +++++++
 rtl/bus1_sram_array.sv | 53 +++++
 rtl/bus1_sram_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bus1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus1_pkg
// Purpose  : Shared types and constants for the CPU-side bus (C1/A1/D1)
//            responder: bus widths, C1 command codes, responder FSM states
//            and small decode helpers used by the responder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bus1_pkg;

  localparam int A1_W      = 15;
  localparam int D1_W      = 16;
  localparam int C1_W      = 3;
  // Full byte address is A1 from cycle 1 followed by A1[3:0] from cycle 2.
  localparam int ADDR_LO_W = 4;
  localparam int ADDR_W    = A1_W + ADDR_LO_W;

  typedef enum logic [C1_W-1:0] {
    C1_NOP        = 3'd0,
    C1_READ8      = 3'd1,
    C1_READ16     = 3'd2,
    C1_READ32     = 3'd3,
    C1_INVALIDATE = 3'd4,
    C1_WRITE8     = 3'd5,
    C1_WRITE16    = 3'd6,
    C1_WRITE32    = 3'd7
  } c1_code_e;

  // Driven by the responder only; shares its encoding with WRITE32.
  localparam logic [C1_W-1:0] C1_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD2  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP1 = 3'd3,
    ST_RESP2 = 3'd4,
    ST_TURN  = 3'd5
  } resp_state_e;

  function automatic logic is_write(input c1_code_e c);
    logic r;
    r = (c == C1_WRITE8) || (c == C1_WRITE16) || (c == C1_WRITE32);
    return r;
  endfunction

  function automatic logic is_read(input c1_code_e c);
    logic r;
    r = (c == C1_READ8) || (c == C1_READ16) || (c == C1_READ32);
    return r;
  endfunction

  // Byte lanes touched by an access, lane 0 at the (aligned) start address.
  function automatic logic [3:0] byte_enables(input c1_code_e c);
    logic [3:0] r;
    case (c)
      C1_READ8,  C1_WRITE8:  r = 4'b0001;
      C1_READ16, C1_WRITE16: r = 4'b0011;
      C1_READ32, C1_WRITE32: r = 4'b1111;
      default:               r = 4'b0000;
    endcase
    return r;
  endfunction

  // 16-bit accesses clear bit 0, 32-bit accesses clear bits [1:0].
  function automatic logic [ADDR_W-1:0] align_addr(input c1_code_e c,
                                                   input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    case (c)
      C1_READ16, C1_WRITE16: r = {a[ADDR_W-1:1], 1'b0};
      C1_READ32, C1_WRITE32: r = {a[ADDR_W-1:2], 2'b00};
      default:               r = a;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus1_sram_array.sv
`default_nettype none
// ============================================================================
// Module   : bus1_sram_array
// Purpose  : Byte-wide SRAM with up to four byte-lane write enables and a
//            32-bit combinational read. Lane i maps to byte (addr + i), so
//            multi-byte accesses wrap modulo 2^ADDR_BITS.
// Ports    : clk   - clock, writes on posedge
//            we    - per-lane write enables (lane 0 = lowest address)
//            waddr - write start byte address
//            wdata - write data, little-endian lanes
//            raddr - read start byte address
//            rdata - read data, little-endian lanes (combinational)
// Notes    : contents have no reset; array starts zero-filled.
// Revision : 1.0 - initial release
// ============================================================================
module bus1_sram_array #(
  parameter int    ADDR_BITS = 16,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic [3:0]           we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr + ADDR_BITS'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[8*i +: 8] = mem[raddr + ADDR_BITS'(i)];
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus1_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus1_sram_responder
// Purpose  : Responder end of the CPU-side bus (C1/A1/D1). Captures a
//            two-cycle command, waits RESP_LAT cycles, then answers with
//            RESPONSE on C1 (plus read data on D1) from an internal
//            byte-addressed SRAM. Drives C1/D1 only in its response window.
// Ports    : clk   - clock, posedge
//            RESET - asynchronous active-low reset (SRAM contents kept)
//            A1    - address lines from the CPU
//            C1    - command/response lines (inout, high-Z when released)
//            D1    - data lines (inout, high-Z when released)
//            busy  - high from command capture until bus release
// Config   : `define BUS1_PROTOCOL_CHECK_EN compiles in a bus protocol
//            checker that raises $error on violations.
// Revision : 1.0 - initial release
// ============================================================================
module bus1_sram_responder
  import bus1_pkg::*;
#(
  parameter int    MEM_ADDR_BITS = 16,
  parameter int    RESP_LAT      = 6,
  parameter string INIT_FILE     = ""
) (
  input  logic            clk,
  input  logic            RESET,
  input  logic [A1_W-1:0] A1,
  inout  wire  [C1_W-1:0] C1,
  inout  wire  [D1_W-1:0] D1,
  output logic            busy
);

  // Counter only needs to hold RESP_LAT-1.
  localparam int CNT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESP_LAT - 1);

  resp_state_e state, state_next;

  c1_code_e              cmd;
  logic [A1_W-1:0]       addr_hi;
  logic [ADDR_LO_W-1:0]  addr_lo;
  logic [31:0]           wdata;
  logic [31:0]           rdata_q;
  logic [CNT_W-1:0]      cnt;

  logic [ADDR_W-1:0]        addr_aligned;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [31:0]              sram_rdata;
  logic [3:0]               sram_we;
  logic                     first_wait;
  logic                     c1_cmd_valid;

  logic            c1_oe;
  logic            d1_oe;
  logic [D1_W-1:0] d1_out;

  logic unused_addr_bits;

  // A floating (Z) or NOP bus is treated as "no command".
  assign c1_cmd_valid = (C1 != C1_NOP);

  assign addr_aligned     = align_addr(cmd, {addr_hi, addr_lo});
  assign mem_addr         = addr_aligned[MEM_ADDR_BITS-1:0];
  assign unused_addr_bits = ^addr_aligned;

  // The counter is loaded with RESP_LAT-1 on WAIT entry, so the load value
  // marks the first WAIT cycle, which is the write commit point.
  assign first_wait = (state == ST_WAIT) && (cnt == CNT_LOAD);
  assign sram_we    = (first_wait && is_write(cmd)) ? byte_enables(cmd) : 4'b0000;

  bus1_sram_array #(
    .ADDR_BITS (MEM_ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .waddr (mem_addr),
    .wdata (wdata),
    .raddr (mem_addr),
    .rdata (sram_rdata)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (c1_cmd_valid) state_next = ST_CMD2;
      ST_CMD2:  state_next = ST_WAIT;
      ST_WAIT:  if (cnt == '0) state_next = ST_RESP1;
      ST_RESP1: state_next = (cmd == C1_READ32) ? ST_RESP2 : ST_TURN;
      ST_RESP2: state_next = ST_TURN;
      ST_TURN:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (bus drive is purely state-decoded so an async reset
  // releases C1/D1 immediately)
  // -------------------------------------------------------------------------
  always_comb begin
    busy   = 1'b0;
    c1_oe  = 1'b0;
    d1_oe  = 1'b0;
    d1_out = '0;
    case (state)
      ST_CMD2, ST_WAIT: busy = 1'b1;
      ST_RESP1: begin
        busy  = 1'b1;
        c1_oe = 1'b1;
        if (is_read(cmd)) begin
          d1_oe  = 1'b1;
          d1_out = (cmd == C1_READ8) ? {8'h00, rdata_q[7:0]} : rdata_q[15:0];
        end
      end
      ST_RESP2: begin
        busy   = 1'b1;
        c1_oe  = 1'b1;
        d1_oe  = 1'b1;
        d1_out = rdata_q[31:16];
      end
      default: ;
    endcase
  end

  assign C1 = c1_oe ? C1_RESPONSE : {C1_W{1'bz}};
  assign D1 = d1_oe ? d1_out      : {D1_W{1'bz}};

  // -------------------------------------------------------------------------
  // Command capture, latency counter and read-data snapshot
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cmd     <= C1_NOP;
      addr_hi <= '0;
      addr_lo <= '0;
      wdata   <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (c1_cmd_valid) begin
            cmd          <= c1_code_e'(C1);
            addr_hi      <= A1;
            wdata[15:0]  <= D1;
          end
        end
        ST_CMD2: begin
          addr_lo <= A1[ADDR_LO_W-1:0];
          if (cmd == C1_WRITE32) begin
            wdata[31:16] <= D1;
          end
          cnt <= CNT_LOAD;
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Sampled on RESP1 entry, after any write commit has landed.
            rdata_q <= sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BUS1_PROTOCOL_CHECK_EN
  // -------------------------------------------------------------------------
  // Protocol checker
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    if (RESET) begin
      if ((state == ST_WAIT) && (C1 !== {C1_W{1'bz}})) begin
        $error("bus1_sram_responder: C1 driven by another agent during WAIT");
      end
      if (((state == ST_RESP1) || (state == ST_RESP2)) && (C1 !== C1_RESPONSE)) begin
        $error("bus1_sram_responder: C1 contention during response");
      end
      if (state == ST_CMD2) begin
        if (((cmd == C1_READ16) || (cmd == C1_WRITE16)) && A1[0]) begin
          $error("bus1_sram_responder: unaligned 16-bit address");
        end
        if (((cmd == C1_READ32) || (cmd == C1_WRITE32)) && (A1[1:0] != 2'b00)) begin
          $error("bus1_sram_responder: unaligned 32-bit address");
        end
      end
    end
  end

  always @(posedge RESET) begin
    for (int i = 0; i < C1_W; i++) begin
      if (C1[i] === 1'bx) begin
        $error("bus1_sram_responder: RESET released while C1 is X");
        break;
      end
    end
  end
`else
  // Checker not built: violations are tolerated, alignment is still forced.
`endif

endmodule
`default_nettype wire
